// File: rtl/iseq_receiver_mc.sv
// iseq_receiver_mc: arbitrates whole instruction sequences from NUM_SRC requesters
// (source 0 has fixed priority, the rest round-robin), stripes each sequence across
// NUM_LANES lane FIFOs, pads the tail with NOPs and pulses process_iseq.
// Optional statistics outputs (iseq_count, pad_count) exist when ISEQ_RECV_STATS_EN is defined.
module iseq_receiver_mc #(
    parameter int unsigned           NUM_SRC     = 2,
    parameter int unsigned           NUM_LANES   = 2,
    parameter int unsigned           INSTR_WIDTH = 32,
    parameter logic [3:0]            END_OPCODE  = 4'hF,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR  = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           dispatcher_ready,
    input  logic [NUM_SRC-1:0]             src_en,
    input  logic [NUM_SRC*INSTR_WIDTH-1:0] src_instr,
    output logic [NUM_SRC-1:0]             src_ack,
    input  logic [NUM_LANES-1:0]           lane_full,
    output logic [NUM_LANES-1:0]           lane_wr_en,
    output logic [INSTR_WIDTH-1:0]         lane_wr_data,
    output logic                           process_iseq,
    output logic                           busy
`ifdef ISEQ_RECV_STATS_EN
    ,
    output logic [31:0]                    iseq_count,
    output logic [31:0]                    pad_count
`endif
);

    localparam int unsigned SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [2:0] {IDLE, RECV, PAD, FIRE, WAIT_ACK} state_e;

    state_e              state_q, state_d;
    logic [SRC_W-1:0]    grant_q, grant_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [LANE_W-1:0]   lane_ptr_q, lane_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                process_iseq_q, process_iseq_d;
    logic                busy_q, busy_d;

    logic                req_found;
    logic [SRC_W-1:0]    req_idx;
    logic [SRC_W-1:0]    rr_next;
    int unsigned         cand;
    logic [INSTR_WIDTH-1:0] sel_instr;
    logic                sel_en;
    logic                sel_full;
    logic                is_end;
    logic [LANE_W-1:0]   lane_ptr_inc;
    logic                lane_wr;
    logic                xfer_ack;

    // Pick the next requester: source 0 first, else first app source at/after rr_ptr
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        cand      = 0;
        if (src_en[0]) begin
            req_found = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_SRC - 1; k++) begin
                cand = ((32'(rr_ptr_q) - 1 + k) % (NUM_SRC - 1)) + 1;
                if (!req_found && src_en[SRC_W'(cand)]) begin
                    req_found = 1'b1;
                    req_idx   = SRC_W'(cand);
                end
            end
        end
        if (req_idx == '0) begin
            rr_next = rr_ptr_q;
        end else if (req_idx == SRC_W'(NUM_SRC - 1)) begin
            rr_next = SRC_W'(1);
        end else begin
            rr_next = req_idx + SRC_W'(1);
        end
    end

    // Mux the granted source and the current lane's full flag
    always_comb begin
        sel_instr = '0;
        sel_en    = 1'b0;
        sel_full  = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_q == SRC_W'(i)) begin
                sel_instr = src_instr[i*INSTR_WIDTH +: INSTR_WIDTH];
                sel_en    = src_en[i];
            end
        end
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (lane_ptr_q == LANE_W'(i)) begin
                sel_full = lane_full[i];
            end
        end
        is_end = (sel_instr[INSTR_WIDTH-1 -: 4] == END_OPCODE);
        if (lane_ptr_q == LANE_W'(NUM_LANES - 1)) begin
            lane_ptr_inc = '0;
        end else begin
            lane_ptr_inc = lane_ptr_q + LANE_W'(1);
        end
    end

    // Next-state logic and combinational handshake outputs
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        lane_ptr_d   = lane_ptr_q;
        cnt_d        = cnt_q;
        src_ack      = '0;
        lane_wr      = 1'b0;
        lane_wr_data = '0;
        xfer_ack     = 1'b0;
        case (state_q)
            IDLE: begin
                if (dispatcher_ready && req_found) begin
                    grant_d    = req_idx;
                    rr_ptr_d   = rr_next;
                    lane_ptr_d = '0;
                    cnt_d      = '0;
                    state_d    = RECV;
                end
            end
            RECV: begin
                xfer_ack = sel_en && !sel_full;
                for (int unsigned i = 0; i < NUM_SRC; i++) begin
                    if (grant_q == SRC_W'(i)) begin
                        src_ack[i] = xfer_ack;
                    end
                end
                if (xfer_ack) begin
                    if (is_end) begin
                        if (cnt_q == '0) begin
                            state_d = IDLE;
                        end else if (lane_ptr_q != '0) begin
                            state_d = PAD;
                        end else begin
                            state_d = FIRE;
                        end
                    end else begin
                        lane_wr      = 1'b1;
                        lane_wr_data = sel_instr;
                        lane_ptr_d   = lane_ptr_inc;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            PAD: begin
                if (!sel_full) begin
                    lane_wr      = 1'b1;
                    lane_wr_data = NOP_INSTR;
                    lane_ptr_d   = lane_ptr_inc;
                    if (lane_ptr_inc == '0) begin
                        state_d = FIRE;
                    end
                end
            end
            FIRE: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!dispatcher_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        process_iseq_d = (state_d == FIRE);
        busy_d         = (state_d != IDLE);
    end

    // Decode the shared write strobe onto the current lane
    always_comb begin
        lane_wr_en = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_wr_en[i] = lane_wr && (lane_ptr_q == LANE_W'(i));
        end
    end

    // State and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            rr_ptr_q       <= SRC_W'(1);
            lane_ptr_q     <= '0;
            cnt_q          <= '0;
            process_iseq_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            rr_ptr_q       <= rr_ptr_d;
            lane_ptr_q     <= lane_ptr_d;
            cnt_q          <= cnt_d;
            process_iseq_q <= process_iseq_d;
            busy_q         <= busy_d;
        end
    end

    assign process_iseq = process_iseq_q;
    assign busy         = busy_q;

`ifdef ISEQ_RECV_STATS_EN
    logic [31:0] iseq_count_q, iseq_count_d;
    logic [31:0] pad_count_q, pad_count_d;

    // Sequence and pad-word counters, free-running with wrap
    always_comb begin
        iseq_count_d = iseq_count_q + 32'(state_q == FIRE);
        pad_count_d  = pad_count_q + 32'((state_q == PAD) && lane_wr);
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iseq_count_q <= '0;
            pad_count_q  <= '0;
        end else begin
            iseq_count_q <= iseq_count_d;
            pad_count_q  <= pad_count_d;
        end
    end

    assign iseq_count = iseq_count_q;
    assign pad_count  = pad_count_q;
`endif

endmodule

// File: tb/tb_iseq_receiver_mc.sv
// Scoreboard bench for iseq_receiver_mc with three sources and two lanes.
module tb_iseq_receiver_mc;

    localparam int unsigned NS    = 3;
    localparam int unsigned NL    = 2;
    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 64;
    localparam logic [W-1:0] NOP  = 32'h0;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            dispatcher_ready = 1'b0;
    logic [NS-1:0]   src_en = '0;
    logic [NS*W-1:0] src_instr = '0;
    logic [NS-1:0]   src_ack;
    logic [NL-1:0]   lane_full = '0;
    logic [NL-1:0]   lane_wr_en;
    logic [W-1:0]    lane_wr_data;
    logic            process_iseq;
    logic            busy;
`ifdef ISEQ_RECV_STATS_EN
    logic [31:0]     iseq_count;
    logic [31:0]     pad_count;
`endif

    iseq_receiver_mc #(
        .NUM_SRC     (NS),
        .NUM_LANES   (NL),
        .INSTR_WIDTH (W),
        .END_OPCODE  (4'hF),
        .NOP_INSTR   (NOP)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dispatcher_ready (dispatcher_ready),
        .src_en           (src_en),
        .src_instr        (src_instr),
        .src_ack          (src_ack),
        .lane_full        (lane_full),
        .lane_wr_en       (lane_wr_en),
        .lane_wr_data     (lane_wr_data),
        .process_iseq     (process_iseq),
        .busy             (busy)
`ifdef ISEQ_RECV_STATS_EN
        ,
        .iseq_count       (iseq_count),
        .pad_count        (pad_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // per-source instruction streams: main writes tails, driver advances heads
    logic [W-1:0] src_mem [NS][DEPTH];
    int           src_head [NS];
    int           src_tail [NS];

    logic [W-1:0] exp_lane0 [$];
    logic [W-1:0] exp_lane1 [$];
    int           exp_grant [$];
    int           exp_fire_q [$];
    int           total_exp_wr = 0;
    int           wr_total = 0;
    int           fire_cnt = 0;
    logic         in_seq = 1'b0;
    logic         hold_ready = 1'b0;
    logic         fire_pending = 1'b0;
    int           disp_busy = 0;
    logic [NS-1:0] acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // queue one sequence of n data words plus END and its expected lane writes
    task automatic push_seq(input int s, input int n);
        logic [W-1:0] w;
        for (int k = 0; k < n; k++) begin
            w = {4'($urandom_range(0, 14)), 28'($urandom)};
            src_mem[s][src_tail[s] % DEPTH] = w;
            src_tail[s]++;
            if (k % 2 == 0) exp_lane0.push_back(w);
            else            exp_lane1.push_back(w);
        end
        w = {4'hF, 28'($urandom)};
        src_mem[s][src_tail[s] % DEPTH] = w;
        src_tail[s]++;
        if (n % 2 == 1) exp_lane1.push_back(NOP);
        exp_grant.push_back(s);
        if (n > 0) begin
            total_exp_wr += n + (n % 2);
            exp_fire_q.push_back(total_exp_wr);
        end
    endtask

    // compare everything the DUT shows in this cycle against the scoreboard
    task automatic monitor();
        int idx;
        int eg;
        int ef;
        logic [W-1:0] d;
        logic [W-1:0] e;
        if (src_ack != '0) begin
            check("ack_onehot", 64'($countones(src_ack)), 64'd1);
            idx = 0;
            for (int s = NS - 1; s >= 0; s--) if (src_ack[s]) idx = s;
            d = src_instr[idx*W +: W];
            if (!in_seq) begin
                if (exp_grant.size() > 0) eg = exp_grant.pop_front();
                else                      eg = 99;
                check("grant", 64'(idx), 64'(eg));
                in_seq = 1'b1;
            end
            if (d[W-1 -: 4] == 4'hF) in_seq = 1'b0;
        end
        if (lane_wr_en != '0) begin
            check("wr_onehot", 64'($countones(lane_wr_en)), 64'd1);
            wr_total++;
            if (lane_wr_en[0]) begin
                if (exp_lane0.size() > 0) e = exp_lane0.pop_front();
                else                      e = 32'hBAD0_BAD0;
                check("lane0_data", 64'(lane_wr_data), 64'(e));
            end
            if (lane_wr_en[1]) begin
                if (exp_lane1.size() > 0) e = exp_lane1.pop_front();
                else                      e = 32'hBAD1_BAD1;
                check("lane1_data", 64'(lane_wr_data), 64'(e));
            end
        end
        if (process_iseq) begin
            fire_cnt++;
            fire_pending = 1'b1;
            if (exp_fire_q.size() > 0) ef = exp_fire_q.pop_front();
            else                       ef = 99999;
            check("fire_after_writes", 64'(wr_total), 64'(ef));
            check("busy_at_fire", 64'(busy), 64'd1);
        end
    endtask

    // sample at negedge, then drive sources and the dispatcher model after posedge
    always begin
        @(negedge clk);
        acc = src_en & src_ack;
        if (rst_n) monitor();
        else       in_seq = 1'b0;
        @(posedge clk);
        #1;
        for (int s = 0; s < NS; s++) if (acc[s]) src_head[s]++;
        if (fire_pending) begin
            disp_busy    = 3;
            fire_pending = 1'b0;
        end else if (disp_busy > 0) begin
            disp_busy--;
        end
        dispatcher_ready = !hold_ready && (disp_busy == 0);
        for (int s = 0; s < NS; s++) begin
            src_en[s]          = (src_head[s] < src_tail[s]);
            src_instr[s*W +: W] = src_mem[s][src_head[s] % DEPTH];
        end
    end

    task automatic wait_fire(input int target, input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (fire_cnt >= target) begin
                done = 1'b1;
                break;
            end
        end
        check({"fire_wait_", tag}, 64'(done), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        logic q_empty;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            q_empty = 1'b1;
            for (int s = 0; s < NS; s++) if (src_head[s] != src_tail[s]) q_empty = 1'b0;
            if (q_empty && !busy && dispatcher_ready && !in_seq) begin
                done = 1'b1;
                break;
            end
        end
        check({"idle_wait_", tag}, 64'(done), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},     64'(src_ack), 64'd0);
        check({tag, "_wr_en"},   64'(lane_wr_en), 64'd0);
        check({tag, "_wr_data"}, 64'(lane_wr_data), 64'd0);
        check({tag, "_fire"},    64'(process_iseq), 64'd0);
        check({tag, "_busy"},    64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int f0;
        logic done;

        // reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_all_zero("rst");
        @(posedge clk); #2;
        rst_n = 1'b1;

        // basic 3-word sequence from src1 with tail padding
        @(posedge clk); #2;
        push_seq(1, 3);
        @(negedge clk);
        @(negedge clk); #1;
        check("ack_before_grant", 64'(src_ack), 64'd0);
        @(negedge clk); #1;
        check("first_ack", 64'(src_ack), 64'b010);
        wait_fire(1, "t1");
        @(negedge clk); #1;
        check("busy_wait_ack", 64'(busy), 64'd1);
        @(negedge clk); #1;
        check("busy_after_drop", 64'(busy), 64'd0);
        wait_idle("t1");

        // src0 and src2 together while dispatcher is busy; src0 wins, then src2
        @(posedge clk); #2;
        hold_ready = 1'b1;
        push_seq(0, 2);
        push_seq(2, 3);
        repeat (3) @(negedge clk);
        #1;
        check("hold_no_ack", 64'(src_ack), 64'd0);
        check("hold_not_busy", 64'(busy), 64'd0);
        @(posedge clk); #2;
        hold_ready = 1'b0;
        wait_fire(fire_cnt + 2, "t2");
        wait_idle("t2");

        // src1 and src2 contending: round-robin 1,2,1,2
        @(posedge clk); #2;
        push_seq(1, 1);
        push_seq(2, 2);
        push_seq(1, 3);
        push_seq(2, 1);
        wait_fire(fire_cnt + 4, "t3");
        wait_idle("t3");

        // lane1 full while lane_ptr=1
        @(posedge clk); #2;
        lane_full = 2'b10;
        w0 = wr_total;
        push_seq(1, 3);
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (wr_total > w0) begin
                done = 1'b1;
                break;
            end
        end
        check("stall_first_wr", 64'(done), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("stall_ack", 64'(src_ack), 64'd0);
            check("stall_wr", 64'(lane_wr_en), 64'd0);
        end
        @(posedge clk); #2;
        lane_full = '0;
        @(negedge clk); #1;
        check("stall_release_wr", 64'(lane_wr_en), 64'b10);
        check("stall_release_ack", 64'(src_ack), 64'b010);
        wait_fire(fire_cnt + 1, "t4");
        wait_idle("t4");

        // END as the first instruction
        @(posedge clk); #2;
        f0 = fire_cnt;
        w0 = wr_total;
        push_seq(1, 0);
        done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (src_head[1] == src_tail[1]) begin
                done = 1'b1;
                break;
            end
        end
        check("empty_consumed", 64'(done), 64'd1);
        check("empty_busy", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        #1;
        check("empty_no_wr", 64'(wr_total), 64'(w0));
        check("empty_no_fire", 64'(fire_cnt), 64'(f0));
        check("empty_no_grant_left", 64'(exp_grant.size()), 64'd0);

        // reset in the middle of a sequence
        @(posedge clk); #2;
        w0 = wr_total;
        push_seq(1, 6);
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (wr_total >= w0 + 3) begin
                done = 1'b1;
                break;
            end
        end
        check("midrst_progress", 64'(done), 64'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        for (int s = 0; s < NS; s++) src_tail[s] = src_head[s];
        exp_lane0.delete();
        exp_lane1.delete();
        exp_grant.delete();
        exp_fire_q.delete();
        total_exp_wr = wr_total;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        push_seq(1, 3);
        push_seq(2, 2);
        wait_fire(fire_cnt + 2, "t6");
        wait_idle("t6");

        check("fires_left", 64'(exp_fire_q.size()), 64'd0);
        check("lane0_left", 64'(exp_lane0.size()), 64'd0);
        check("lane1_left", 64'(exp_lane1.size()), 64'd0);
        check("grants_left", 64'(exp_grant.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
